serial_adder_sub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor; the next generation of the team's fixed-width ripple-carry adder.
- Processes operands CHUNK bits per clock, so one narrow CHUNK-bit adder serves any WIDTH.
- Adds a subtract mode, signed overflow detection and a start/busy/done handshake for use inside the datapath controllers.

---
 rtl/serial_adder_sub.sv | 139 +++++++++++++
 tb/tb_serial_adder_sub.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple adder is reused over
// WIDTH/CHUNK cycles. start/busy/done handshake; subtraction is A + ~B + 1.
//
//   state  | meaning
//   IDLE   | waiting for start, outputs hold last result
//   RUN    | one chunk of the operands added per cycle
//   DONE   | done pulse; a new start is accepted here without a bubble
module serial_adder_sub #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);

  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_RUN  = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST   = CW'(NCH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic [WIDTH-1:0] work_next;
  logic             accept;

  // Operands shift right one chunk per cycle, so the adder always reads the
  // low CHUNK bits; carry into the top bit is kept for overflow detection.
  always_comb begin : chunk_adder
    logic c;
    c          = carry_q;
    chunk_cmsb = 1'b0;
    chunk_sum  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
      if (i == CHUNK - 1) chunk_cmsb = c;
      c = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chunk_cout = c;
  end

  // Working sum fills from the top; after NCH chunks chunk k sits at k*CHUNK.
  assign work_next = (work_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
  assign accept    = start_i && (state_q != S_RUN);

  // Next-state and datapath load/step logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CW'(1);
        work_d  = work_next;
        if (cnt_q == LAST) begin
          sum_d   = work_next;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          cnt_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed checks on the default 10-bit/2-bit instance plus a 16-bit sweep
// over CHUNK = 1, 4 and 16 against an arithmetic reference.
module tb_serial_adder_sub;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  // default instance
  logic       start_i = 1'b0, sub_i = 1'b0, cin_i = 1'b0;
  logic [9:0] a_i = '0, b_i = '0;
  logic       busy_o, done_o, cout_o, ovf_o;
  logic [9:0] sum_o;

  serial_adder_sub dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sub_i(sub_i),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o)
  );

  // 16-bit sweep instances sharing one stimulus
  logic        st16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  busy16, done16, cout16, ovf16;
  logic [15:0] sum16 [3];

  serial_adder_sub #(.WIDTH(16), .CHUNK(1)) dut_c1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(st16), .sub_i(sub16),
    .a_i(a16), .b_i(b16), .cin_i(cin16), .busy_o(busy16[0]), .done_o(done16[0]),
    .sum_o(sum16[0]), .cout_o(cout16[0]), .ovf_o(ovf16[0])
  );
  serial_adder_sub #(.WIDTH(16), .CHUNK(4)) dut_c4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(st16), .sub_i(sub16),
    .a_i(a16), .b_i(b16), .cin_i(cin16), .busy_o(busy16[1]), .done_o(done16[1]),
    .sum_o(sum16[1]), .cout_o(cout16[1]), .ovf_o(ovf16[1])
  );
  serial_adder_sub #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(st16), .sub_i(sub16),
    .a_i(a16), .b_i(b16), .cin_i(cin16), .busy_o(busy16[2]), .done_o(done16[2]),
    .sum_o(sum16[2]), .cout_o(cout16[2]), .ovf_o(ovf16[2])
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an operation in the current cycle; it is accepted at the next edge.
  task automatic drive10(input logic s, input logic [9:0] a, input logic [9:0] b, input logic c);
    sub_i = s; a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
  endtask

  // From the accepting edge (edge 1) count edges until done is seen, and
  // count samples with busy high. Optionally pulse start and scramble the
  // inputs mid-run.
  task automatic wait10(input bit glitch, output int edges, output int busy_cnt);
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    edges    = 1;
    busy_cnt = int'(busy_o);
    while (!done_o && edges < 40) begin
      @(posedge clk_i); #1;
      edges++;
      busy_cnt += int'(busy_o);
      if (glitch && edges == 2) begin
        start_i = 1'b1; a_i = 10'h3AA; b_i = 10'h155; sub_i = 1'b1; cin_i = 1'b1;
      end
      if (glitch && edges == 3) start_i = 1'b0;
    end
    if (!done_o) chk("done_timeout", 32'(edges), 32'd6);
  endtask

  task automatic op10(input string tag, input logic s, input logic [9:0] a, input logic [9:0] b,
                      input logic c, input logic [9:0] e_sum, input logic e_cout, input logic e_ovf);
    int edges, bc;
    @(negedge clk_i);
    drive10(s, a, b, c);
    wait10(1'b0, edges, bc);
    chk({tag, "_res"}, {20'd0, cout_o, ovf_o, sum_o}, {20'd0, e_cout, e_ovf, e_sum});
    chk({tag, "_lat"}, 32'(edges), 32'd6);
  endtask

  // 16-bit reference: wide addition, overflow from operand/result signs.
  function automatic logic [17:0] ref16(input logic s, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    logic [15:0] bb;
    logic [16:0] full;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
    v    = (a[15] == bb[15]) && (full[15] != a[15]);
    return {full[16], v, full[15:0]};
  endfunction

  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c);
    int lat [3];
    int edges;
    logic [17:0] e;
    @(negedge clk_i);
    sub16 = s; a16 = a; b16 = b; cin16 = c; st16 = 1'b1;
    @(posedge clk_i); #1;
    st16  = 1'b0;
    edges = 1;
    lat   = '{0, 0, 0};
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && edges < 40) begin
      @(posedge clk_i); #1;
      edges++;
      for (int j = 0; j < 3; j++)
        if (done16[j] && lat[j] == 0) lat[j] = edges;
    end
    e = ref16(s, a, b, c);
    chk("c1_res",  {14'd0, cout16[0], ovf16[0], sum16[0]}, {14'd0, e});
    chk("c4_res",  {14'd0, cout16[1], ovf16[1], sum16[1]}, {14'd0, e});
    chk("c16_res", {14'd0, cout16[2], ovf16[2], sum16[2]}, {14'd0, e});
    chk("c1_lat",  32'(lat[0]), 32'd17);
    chk("c4_lat",  32'(lat[1]), 32'd5);
    chk("c16_lat", 32'(lat[2]), 32'd2);
  endtask

  initial begin
    int edges, bc, edges2;
    bit saw_done;

    #12;
    chk("rst_outputs", {19'd0, busy_o, done_o, cout_o, ovf_o, sum_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_outputs", {19'd0, busy_o, done_o, cout_o, ovf_o, sum_o}, 32'd0);

    // basic add, with handshake timing
    drive10(1'b0, 10'd300, 10'd200, 1'b0);
    wait10(1'b0, edges, bc);
    chk("add_res", {20'd0, cout_o, ovf_o, sum_o}, {20'd0, 1'b0, 1'b0, 10'd500});
    chk("add_lat", 32'(edges), 32'd6);
    chk("add_busy_cycles", 32'(bc), 32'd5);
    chk("add_done_busy", {30'd0, busy_o, done_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("done_one_cycle", {30'd0, busy_o, done_o}, 32'd0);
    chk("sum_held", {22'd0, sum_o}, 32'd500);

    op10("wrap",    1'b0, 10'h3FF, 10'h001, 1'b1, 10'h001, 1'b1, 1'b0);
    op10("add_ovf", 1'b0, 10'h1FF, 10'h001, 1'b0, 10'h200, 1'b0, 1'b1);
    op10("sub_brw", 1'b1, 10'd5,   10'd7,   1'b0, 10'h3FE, 1'b0, 1'b0);
    op10("sub_ovf", 1'b1, 10'h200, 10'h001, 1'b0, 10'h1FF, 1'b1, 1'b1);
    op10("sub_eq",  1'b1, 10'h155, 10'h155, 1'b1, 10'h000, 1'b1, 1'b0);
    op10("neg_add", 1'b0, 10'h200, 10'h200, 1'b0, 10'h000, 1'b1, 1'b1);

    // start and input changes during RUN must be ignored
    @(negedge clk_i);
    drive10(1'b0, 10'd100, 10'd23, 1'b0);
    wait10(1'b1, edges, bc);
    chk("ign_res", {20'd0, cout_o, ovf_o, sum_o}, {20'd0, 1'b0, 1'b0, 10'd123});
    chk("ign_lat", 32'(edges), 32'd6);
    @(posedge clk_i); #1;
    chk("ign_no_restart", {31'd0, busy_o}, 32'd0);

    // back-to-back: start asserted in the DONE cycle
    @(negedge clk_i);
    drive10(1'b0, 10'd7, 10'd8, 1'b1);
    wait10(1'b0, edges, bc);
    chk("b2b_first", {22'd0, sum_o}, 32'd16);
    drive10(1'b1, 10'd40, 10'd50, 1'b0);
    wait10(1'b0, edges2, bc);
    chk("b2b_gap", 32'(edges2), 32'd6);
    chk("b2b_second", {20'd0, cout_o, ovf_o, sum_o}, {20'd0, 1'b0, 1'b0, 10'h3F6});

    // asynchronous reset on the 3rd RUN cycle
    @(negedge clk_i);
    drive10(1'b0, 10'd1, 10'd2, 1'b0);
    @(posedge clk_i); #1; start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i); #2;
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("async_rst", {19'd0, busy_o, done_o, cout_o, ovf_o, sum_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) saw_done = 1'b1;
    end
    chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    op10("post_rst", 1'b0, 10'd250, 10'd260, 1'b1, 10'd511, 1'b0, 1'b0);

    // 16-bit sweep
    op16(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    op16(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    op16(1'b1, 16'h8000, 16'h0001, 1'b1);
    op16(1'b1, 16'h1234, 16'h1234, 1'b0);
    for (int k = 0; k < 1000; k++)
      op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
